// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider: state encodings, result/control constants
// and the stall-bus shape the pipeline uses alongside them.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BY_ZERO = 2'b01,
        ON      = 2'b10,
        END     = 2'b11
    } div_state_t;

    localparam logic [63:0] DIV_RESULT_ZERO = 64'h0;
    localparam int          DIV_ITERATIONS  = 32;

    localparam logic DIV_START     = 1'b1;
    localparam logic DIV_STOP      = 1'b0;
    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;

    localparam int         STALL_BUS_W = 6;
    localparam logic [5:0] STALL_NONE  = 6'b000000;

    // Magnitude of a 32-bit operand; unsigned operands pass through untouched.
    function automatic logic [31:0] abs_if(input logic is_signed, input logic [31:0] v);
        return (is_signed && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on the {remainder[32:0], quotient[31:0]} register.
module div_step (
    input  logic [64:0] acc,
    input  logic [31:0] divisor,
    output logic [64:0] acc_next
);

    logic [33:0] shifted;
    logic [33:0] diff;

    // diff[33] is the borrow: the shifted partial remainder is below the divisor.
    assign shifted  = {acc[64:32], acc[31]};
    assign diff     = shifted - {2'b00, divisor};
    assign acc_next = diff[33] ? {shifted[32:0], acc[30:0], 1'b0}
                               : {diff[32:0],    acc[30:0], 1'b1};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit divider controller: operand capture, 32 restoring steps,
// sign fix-up, and the result/ready handshake back to EX.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o,
    output div_state_t  state
);

    logic [5:0]  cnt;
    logic [64:0] acc;
    logic [31:0] divisor;
    logic        sign_a;
    logic        sign_b;
    logic        is_signed;
    logic [64:0] acc_step;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    div_step u_step (
        .acc      (acc),
        .divisor  (divisor),
        .acc_next (acc_step)
    );

    // Sign fix-up is applied to the output of the final step as END is entered.
    assign quo_fix = (is_signed && (sign_a ^ sign_b)) ? -acc_step[31:0]  : acc_step[31:0];
    assign rem_fix = (is_signed && sign_a)            ? -acc_step[63:32] : acc_step[63:32];

    assign stallreq_o = ~rst & (((state == IDLE) & start_i & ~annul_i)
                                | (state == BY_ZERO) | (state == ON));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            acc       <= 65'd0;
            divisor   <= 32'd0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            is_signed <= 1'b0;
            result_o  <= DIV_RESULT_ZERO;
            ready_o   <= DIV_NOT_READY;
        end else begin
            case (state)
                IDLE: begin
                    result_o <= DIV_RESULT_ZERO;
                    ready_o  <= DIV_NOT_READY;
                    if (start_i == DIV_START && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state <= BY_ZERO;
                        end else begin
                            state     <= ON;
                            cnt       <= 6'd0;
                            acc       <= {33'd0, abs_if(signed_div_i, opdata1_i)};
                            divisor   <= abs_if(signed_div_i, opdata2_i);
                            sign_a    <= opdata1_i[31];
                            sign_b    <= opdata2_i[31];
                            is_signed <= signed_div_i;
                        end
                    end
                end
                BY_ZERO: begin
                    acc   <= {1'b0, DIV_RESULT_ZERO};
                    state <= END;
                end
                ON: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'(DIV_ITERATIONS - 1)) begin
                            acc   <= {1'b0, rem_fix, quo_fix};
                            state <= END;
                        end else begin
                            acc <= acc_step;
                        end
                    end
                end
                END: begin
                    if (start_i == DIV_START) begin
                        ready_o  <= DIV_READY;
                        result_o <= acc[63:0];
                    end else begin
                        state    <= IDLE;
                        ready_o  <= DIV_NOT_READY;
                        result_o <= DIV_RESULT_ZERO;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: table of divides with hand-computed results and
// latencies, plus annul and asynchronous-reset sequences.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;
    div_state_t  state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // First step() is the acceptance edge T; e counts edges after T.
    task automatic wait_result(input logic [63:0] exp_res, input int exp_lat, input string name);
        int lat;
        bit stall_ok;
        bit saw_on;
        lat      = -1;
        stall_ok = 1'b1;
        saw_on   = 1'b0;
        for (int e = 0; e <= 40; e++) begin
            step();
            if (e == 0) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            if (state == ON) saw_on = 1'b1;
            if (ready_o) begin
                lat = e;
                break;
            end
            if (stallreq_o !== (e < exp_lat - 1)) stall_ok = 1'b0;
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_stall_window"}, {63'd0, stall_ok}, 64'd1);
        check({name, "_stall_in_end"}, {63'd0, stallreq_o}, 64'd0);
        check({name, "_result"}, result_o, exp_res);
        if (exp_lat == 2) check({name, "_no_on_cycles"}, {63'd0, saw_on}, 64'd0);
        step();
        check({name, "_ready_held"}, {63'd0, ready_o}, 64'd1);
        check({name, "_result_held"}, result_o, exp_res);
        start_i = 1'b0;
        step();
        check({name, "_ready_drop"}, {63'd0, ready_o}, 64'd0);
        check({name, "_result_drop"}, result_o, 64'd0);
        check({name, "_idle_after"}, {62'd0, state}, {62'd0, IDLE});
    endtask

    task automatic run_div(input vec_t v, input string name);
        signed_div_i = v.sgn;
        opdata1_i    = v.a;
        opdata2_i    = v.b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        #1;
        check({name, "_stall_on_request"}, {63'd0, stallreq_o}, 64'd1);
        wait_result({v.r, v.q}, v.lat, name);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          33};
        vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0,          2};
        vecs[4]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'd0,          32'd0,          2};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          33};
        vecs[6]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   33};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          32'd1,          33};
        vecs[8]  = '{1'b0, 32'h80000000,   32'h80000001,   32'd0,          32'h80000000,   33};
        vecs[9]  = '{1'b0, 32'd1000,       32'd1000,       32'd1,          32'd0,          33};
        vecs[10] = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          33};
        vecs[11] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          33};
        vecs[12] = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[13] = '{1'b0, 32'd3,          32'd7,          32'd0,          32'd3,          33};

        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        step();
        step();
        check("reset_state", {62'd0, state}, {62'd0, IDLE});
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_stall", {63'd0, stallreq_o}, 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 14; i++) begin
            run_div(vecs[i], $sformatf("vec%0d", i));
            step();
        end

        // Annul mid-divide, then restart with new operands while start stays high.
        begin
            bit ready_seen;
            ready_seen   = 1'b0;
            signed_div_i = 1'b0;
            opdata1_i    = 32'd100;
            opdata2_i    = 32'd7;
            start_i      = 1'b1;
            for (int e = 0; e <= 10; e++) begin
                step();
                if (ready_o) ready_seen = 1'b1;
            end
            annul_i = 1'b1;
            step();
            annul_i   = 1'b0;
            opdata1_i = 32'd1000;
            opdata2_i = 32'd33;
            if (ready_o) ready_seen = 1'b1;
            check("annul_to_idle", {62'd0, state}, {62'd0, IDLE});
            check("annul_no_ready", {63'd0, ready_seen}, 64'd0);
            check("annul_result_zero", result_o, 64'd0);
            wait_result({32'd10, 32'd30}, 33, "after_annul");
            step();
        end

        // Asynchronous reset in the middle of ON.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd7;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        for (int e = 0; e < 20; e++) step();
        check("pre_reset_on", {62'd0, state}, {62'd0, ON});
        #2 rst = 1'b1;
        #1;
        check("areset_on_state", {62'd0, state}, {62'd0, IDLE});
        check("areset_on_stall", {63'd0, stallreq_o}, 64'd0);
        check("areset_on_ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        run_div(vecs[11], "overflow_after_reset");
        step();

        // Asynchronous reset while a result is being presented.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        for (int e = 0; e <= 33; e++) step();
        check("pre_reset_ready", {63'd0, ready_o}, 64'd1);
        check("pre_reset_result", result_o, {32'd2, 32'd14});
        #2 rst = 1'b1;
        #1;
        check("areset_end_ready", {63'd0, ready_o}, 64'd0);
        check("areset_end_result", result_o, 64'd0);
        check("areset_end_state", {62'd0, state}, {62'd0, IDLE});
        start_i = 1'b0;
        step();
        rst = 1'b0;
        step();
        run_div(vecs[0], "first_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state changes on posedge clk.
REQ-002 SHALL provide port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide port: signed_div_i  input  1  1 = signed (div), 0 = unsigned (divu); sampled at start acceptance.
REQ-004 SHALL provide port: opdata1_i  input  32  dividend; sampled at start acceptance.
REQ-005 SHALL provide port: opdata2_i  input  32  divisor; sampled at start acceptance.
REQ-006 SHALL provide port: start_i  input  1  divide request from EX; held high until ready_o is seen.
REQ-007 SHALL provide port: annul_i  input  1  pipeline flush; cancels an in-flight divide.
REQ-008 SHALL provide port: result_o  output  64  {remainder[63:32], quotient[31:0]}.
REQ-009 SHALL provide port: ready_o  output  1  result_o valid.
REQ-010 SHALL provide port: stallreq_o  output  1  request to stall the pipeline while the divide is outstanding.

Function
REQ-011 SHALL implement FSM states IDLE, BY_ZERO, ON, END.
REQ-012 IDLE: start_i=1 & annul_i=0 & opdata2_i=0 -> BY_ZERO; start_i=1 & annul_i=0 & opdata2_i!=0 -> ON; otherwise remain in IDLE.
REQ-013 On IDLE->ON, SHALL latch |dividend| and |divisor| (absolute values only when signed_div_i=1), the operand signs and signed_div_i, and SHALL clear the 6-bit iteration counter.
REQ-014 ON: each cycle SHALL perform one restoring shift-subtract step on a 65-bit partial-remainder/quotient register and increment the counter; after exactly 32 steps -> END.
REQ-015 BY_ZERO: SHALL go to END on the next cycle with result forced to 64'h0.
REQ-016 ON with annul_i=1 SHALL go to IDLE on the next edge; no result shall be produced.
REQ-017 Sign correction on entry to END (signed only): quotient negated when dividend and divisor signs differ; remainder takes the dividend's sign.
REQ-018 END: ready_o=1 and result_o held stable while start_i=1; start_i=0 -> IDLE, with ready_o=0 and result_o=0 from the next cycle.
REQ-019 Latency: start accepted at edge T -> ready_o=1 from T+33 (nonzero divisor) or T+2 (zero divisor).
REQ-020 stallreq_o SHALL be combinational: (IDLE & start_i & ~annul_i) | BY_ZERO | ON; it SHALL be 0 in END.
REQ-021 Outside END, result_o SHALL be 64'h0 and ready_o SHALL be 0.
REQ-022 Overflow: signed 32'h80000000 / 32'hFFFFFFFF SHALL give quotient 32'h80000000 (wrap) and remainder 0, with no exception signal.
REQ-023 Operand changes after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-024 rst=1 SHALL force IDLE immediately and clear the counter, the 65-bit register, result_o, ready_o and stallreq_o, asynchronously and at any state, including mid-ON.
REQ-025 After rst deassertion, the first accepted start SHALL behave identically to a post-idle start.

Structure
REQ-026 The state encodings (2-bit), DivResultZero (64'h0), DivIterations (32) and the Div* control constants SHALL live in the shared defines header next to the StallBus definitions.
REQ-027 One sub-module SHALL exist: div_step, a combinational single shift-subtract iteration (65-bit in -> 65-bit out); div_ctrl SHALL own the FSM, counter, sign handling and registers.

Verification
REQ-028 Unsigned 100/7, start held -> ready_o at T+33, result_o={32'd2, 32'd14}, stallreq_o=1 for cycles T..T+32.
REQ-029 Signed -7/2 -> quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF; signed 7/-2 -> quotient 32'hFFFFFFFD, remainder 32'd1.
REQ-030 Divisor 0 (any dividend) -> ready_o at T+2, result_o=64'h0, no ON cycles.
REQ-031 annul_i pulsed at T+10 of a divide -> IDLE at T+11, ready_o never asserted; a new start at T+12 completes at T+45 with a correct result.
REQ-032 rst asserted asynchronously at T+20 -> all outputs 0 before the next edge; signed 32'h80000000/32'hFFFFFFFF after reset -> {32'h0, 32'h80000000}.
REQ-033 Unsigned 32'hFFFFFFFF/32'd1 -> {32'h0, 32'hFFFFFFFF}; start_i dropped in END -> ready_o=0 and result_o=0 next cycle.
